riscv_lsu: RTL and testbench

- Load/store unit directly downstream of the single-cycle RISC-V core's data-memory port.
- Turns the core's size-coded requests into a byte-enabled 32-bit memory bus transaction with a ready handshake.
- Generates the core's `stall_i` while an access is outstanding, and returns sign/zero-extended load data.
- Includes a watchdog that releases a hung access with a bus-error pulse.

---
 rtl/riscv_lsu_pkg.sv | 15 +
 rtl/riscv_lsu_if.sv | 52 +++++
 rtl/riscv_lsu_lane_mux.sv | 56 +++++
 rtl/riscv_lsu.sv | 122 ++++++++++++
 tb/tb_riscv_lsu.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes and FSM states.
package riscv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/riscv_lsu_if.sv
// Core-side and memory-side signals of the load/store unit.
// Carries misalign_o only when LSU_MISALIGN_EN is defined.
interface riscv_lsu_if;

    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        bus_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;
`ifdef LSU_MISALIGN_EN
    logic        misalign_o;

    modport slave (
        input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        input  mem_rd_i, mem_ready_i,
        output core_rd_o, core_stall_o, bus_err_o, misalign_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );

    modport master (
        output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        output mem_rd_i, mem_ready_i,
        input  core_rd_o, core_stall_o, bus_err_o, misalign_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );
`else
    modport slave (
        input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        input  mem_rd_i, mem_ready_i,
        output core_rd_o, core_stall_o, bus_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );

    modport master (
        output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        output mem_rd_i, mem_ready_i,
        input  core_rd_o, core_stall_o, bus_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );
`endif

endinterface

// File: rtl/riscv_lsu_lane_mux.sv
// Byte-lane steering: store byte enables / data replication and load extraction.
module lsu_lane_mux
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wd,
    input  logic [31:0] rd_word,
    output logic [3:0]  be,
    output logic [31:0] wd_rep,
    output logic [31:0] rd_ext
);

    function automatic logic [31:0] sext_b(input logic signed [7:0] v);
        return 32'(v);
    endfunction

    function automatic logic [31:0] sext_h(input logic signed [15:0] v);
        return 32'(v);
    endfunction

    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;

    always_comb begin
        lane_b = rd_word[{addr_lo, 3'b000} +: 8];
        lane_h = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
        be     = 4'b1111;
        wd_rep = wd;
        rd_ext = rd_word;
        case (size)
            LDST_B: begin
                be     = 4'b0001 << addr_lo;
                wd_rep = {4{wd[7:0]}};
                rd_ext = sext_b(lane_b);
            end
            LDST_BU: begin
                be     = 4'b0001 << addr_lo;
                wd_rep = {4{wd[7:0]}};
                rd_ext = {24'd0, lane_b};
            end
            LDST_H: begin
                be     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wd_rep = {2{wd[15:0]}};
                rd_ext = sext_h(lane_h);
            end
            LDST_HU: begin
                be     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wd_rep = {2{wd[15:0]}};
                rd_ext = {16'd0, lane_h};
            end
            default: ; // W and the unused codes behave as a full word
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: request/stall FSM with watchdog between core and memory bus.
// Optional LSU_MISALIGN_EN rejects misaligned H/W accesses via misalign_o.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input logic        clk_i,
    input logic        rst_i,
    riscv_lsu_if.slave bus
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
    localparam bit               WD_EN  = (TIMEOUT != 0);

    lsu_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             misal;
    logic             expire;
    logic [31:0]      rd_ext;

    lsu_lane_mux u_lane (
        .size    (bus.core_size_i),
        .addr_lo (bus.core_addr_i[1:0]),
        .wd      (bus.core_wd_i),
        .rd_word (bus.mem_rd_i),
        .be      (bus.mem_be_o),
        .wd_rep  (bus.mem_wd_o),
        .rd_ext  (rd_ext)
    );

    assign bus.mem_addr_o = {bus.core_addr_i[31:2], 2'b00};

`ifdef LSU_MISALIGN_EN
    always_comb begin
        case (bus.core_size_i)
            LDST_B, LDST_BU: misal = 1'b0;
            LDST_H, LDST_HU: misal = bus.core_addr_i[0];
            default:         misal = |bus.core_addr_i[1:0];
        endcase
    end
`else
    assign misal = 1'b0;
`endif

    assign expire = WD_EN && (cnt == TO_CNT);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.core_req_i && !misal) begin
                    state_nxt = WAIT;
                    cnt_nxt   = '0;
                end
            end
            WAIT: begin
                // A dropped request (trap), completion or watchdog expiry all end the access
                if (!bus.core_req_i || bus.mem_ready_i || expire) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req_o    = 1'b0;
        bus.core_stall_o = 1'b0;
        bus.bus_err_o    = 1'b0;
        bus.core_rd_o    = '0;
`ifdef LSU_MISALIGN_EN
        bus.misalign_o   = 1'b0;
`endif
        // Outputs are gated by reset so the core's PC can reset while the LSU is idle
        if (rst_i) begin
            case (state)
                IDLE: begin
                    if (bus.core_req_i) begin
                        if (misal) begin
`ifdef LSU_MISALIGN_EN
                            bus.misalign_o = 1'b1;
`endif
                        end else begin
                            bus.mem_req_o    = 1'b1;
                            bus.core_stall_o = 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (bus.core_req_i) begin
                        bus.mem_req_o = 1'b1;
                        if (bus.mem_ready_i) begin
                            bus.core_rd_o = rd_ext;
                        end else if (expire) begin
                            bus.bus_err_o = 1'b1;
                        end else begin
                            bus.core_stall_o = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        bus.mem_we_o = bus.mem_req_o & bus.core_we_i;
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized self-checking bench for riscv_lsu against a byte-arithmetic reference model.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  size = 3'd0;
    logic [31:0] addr = '0;
    logic [31:0] wdat = '0;
    logic [31:0] mrd = '0;
    logic        rdy = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_lsu_if u_if ();
    riscv_lsu_if w_if ();

    assign u_if.core_req_i  = req;
    assign u_if.core_we_i   = we;
    assign u_if.core_size_i = size;
    assign u_if.core_addr_i = addr;
    assign u_if.core_wd_i   = wdat;
    assign u_if.mem_rd_i    = mrd;
    assign u_if.mem_ready_i = rdy;
    assign w_if.core_req_i  = req;
    assign w_if.core_we_i   = we;
    assign w_if.core_size_i = size;
    assign w_if.core_addr_i = addr;
    assign w_if.core_wd_i   = wdat;
    assign w_if.mem_rd_i    = mrd;
    assign w_if.mem_ready_i = rdy;

    riscv_lsu #(.TIMEOUT(255), .CNT_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (u_if.slave)
    );

    riscv_lsu #(.TIMEOUT(4), .CNT_W(8)) dut_wd (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (w_if.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: access width in bytes and lane offset from plain arithmetic
    function automatic int nbytes(input logic [2:0] sz);
        if (sz == 3'd0 || sz == 3'd4) return 1;
        if (sz == 3'd1 || sz == 3'd5) return 2;
        return 4;
    endfunction

    function automatic int lane_off(input logic [2:0] sz, input logic [31:0] a);
        int n = nbytes(sz);
        if (n == 4) return 0;
        return (int'(a % 4) / n) * n;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [31:0] a);
        int n = nbytes(sz);
        longint m = ((longint'(1) << n) - 1) << lane_off(sz, a);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] sz, input logic [31:0] d);
        int n = nbytes(sz);
        longint v = longint'(d) % (longint'(1) << (8 * n));
        longint r = 0;
        for (int i = 0; i < 4 / n; i++) r = r + (v << (8 * n * i));
        return r[31:0];
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        int n = nbytes(sz);
        longint span = longint'(1) << (8 * n);
        longint v = (longint'(d) >> (8 * lane_off(sz, a))) % span;
        if ((sz == 3'd0 || sz == 3'd1) && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // One complete access on the main instance: request cycle, dly wait cycles, ready cycle, idle
    task automatic do_access(input logic we_v, input logic [2:0] sz, input logic [31:0] a,
                             input logic [31:0] wdv, input logic [31:0] rdv, input int dly,
                             input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd);
        next_cyc();
        req = 1'b1; we = we_v; size = sz; addr = a; wdat = wdv;
        mrd = $urandom; rdy = 1'($urandom_range(0, 1));
        #2;
        check_eq("req_stall", 32'(u_if.core_stall_o), 32'd1);
        check_eq("req_memreq", 32'(u_if.mem_req_o), 32'd1);
        check_eq("req_we", 32'(u_if.mem_we_o), 32'(we_v));
        check_eq("req_be", 32'(u_if.mem_be_o), 32'(ebe));
        check_eq("req_wd", u_if.mem_wd_o, ewd);
        check_eq("req_addr", u_if.mem_addr_o, a & 32'hFFFF_FFFC);
        check_eq("req_rd0", u_if.core_rd_o, 32'd0);
`ifdef LSU_MISALIGN_EN
        check_eq("req_misal", 32'(u_if.misalign_o), 32'd0);
`endif
        for (int i = 0; i < dly; i++) begin
            next_cyc();
            rdy = 1'b0; mrd = $urandom;
            #2;
            check_eq("wait_stall", 32'(u_if.core_stall_o), 32'd1);
            check_eq("wait_memreq", 32'(u_if.mem_req_o), 32'd1);
            check_eq("wait_be", 32'(u_if.mem_be_o), 32'(ebe));
            check_eq("wait_rd0", u_if.core_rd_o, 32'd0);
        end
        next_cyc();
        rdy = 1'b1; mrd = rdv;
        #2;
        check_eq("rdy_stall", 32'(u_if.core_stall_o), 32'd0);
        check_eq("rdy_err", 32'(u_if.bus_err_o), 32'd0);
        if (!we_v) check_eq("rdy_rd", u_if.core_rd_o, erd);
        next_cyc();
        req = 1'b0; rdy = 1'b0;
        #2;
        check_eq("idle_stall", 32'(u_if.core_stall_o), 32'd0);
        check_eq("idle_memreq", 32'(u_if.mem_req_o), 32'd0);
        check_eq("idle_rd0", u_if.core_rd_o, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [2:0]  sz;
        logic [31:0] a, d, r;
        logic        wv;

        // Reset holds all outputs low even with a request present
        req = 1'b1; size = 3'd2; addr = 32'h40;
        #3;
        check_eq("rst_stall", 32'(u_if.core_stall_o), 32'd0);
        check_eq("rst_memreq", 32'(u_if.mem_req_o), 32'd0);
        check_eq("rst_err", 32'(u_if.bus_err_o), 32'd0);
        check_eq("rst_rd", u_if.core_rd_o, 32'd0);
        next_cyc(); next_cyc();
        req = 1'b0;
        #2 rst_n = 1'b1;

        // Directed accesses with hand-derived expectations
        do_access(1'b1, 3'd0, 32'h103, 32'hAABBCCDD, 32'h0, 0, 4'b1000, 32'hDDDDDDDD, 32'h0);
        do_access(1'b0, 3'd0, 32'h2, 32'h0, 32'h0080_0000, 0, 4'b0100, 32'h0, 32'hFFFFFF80);
        do_access(1'b0, 3'd4, 32'h2, 32'h0, 32'h0080_0000, 0, 4'b0100, 32'h0, 32'h00000080);
        do_access(1'b0, 3'd1, 32'h2, 32'h0, 32'h8001_1234, 1, 4'b1100, 32'h0, 32'hFFFF8001);
        do_access(1'b0, 3'd2, 32'h40, 32'h0, 32'h1234_5678, 5, 4'b1111, 32'h0, 32'h12345678);

        // Watchdog expiry on the TIMEOUT=4 instance
        next_cyc();
        req = 1'b1; we = 1'b0; size = 3'd2; addr = 32'h80; rdy = 1'b0; mrd = 32'hDEADBEEF;
        #2;
        check_eq("wd_req_stall", 32'(w_if.core_stall_o), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            next_cyc();
            #2;
            check_eq("wd_wait_stall", 32'(w_if.core_stall_o), 32'd1);
            check_eq("wd_wait_err", 32'(w_if.bus_err_o), 32'd0);
        end
        next_cyc();
        #2;
        check_eq("wd_exp_stall", 32'(w_if.core_stall_o), 32'd0);
        check_eq("wd_exp_err", 32'(w_if.bus_err_o), 32'd1);
        check_eq("wd_exp_rd", w_if.core_rd_o, 32'd0);
        check_eq("main_no_err", 32'(u_if.bus_err_o), 32'd0);
        check_eq("main_still_stall", 32'(u_if.core_stall_o), 32'd1);
        next_cyc();
        req = 1'b0;
        #2;
        check_eq("wd_after_err", 32'(w_if.bus_err_o), 32'd0);
        check_eq("wd_after_memreq", 32'(w_if.mem_req_o), 32'd0);

        // Ready arriving on the expiry cycle wins
        next_cyc();
        req = 1'b1; size = 3'd2; addr = 32'h84; rdy = 1'b0;
        #2;
        for (int i = 0; i < 4; i++) begin
            next_cyc();
            #2;
        end
        next_cyc();
        rdy = 1'b1; mrd = 32'hCAFEF00D;
        #2;
        check_eq("wd_tie_stall", 32'(w_if.core_stall_o), 32'd0);
        check_eq("wd_tie_err", 32'(w_if.bus_err_o), 32'd0);
        check_eq("wd_tie_rd", w_if.core_rd_o, 32'hCAFEF00D);
        next_cyc();
        req = 1'b0; rdy = 1'b0;

        // Core trap: request dropped mid-wait
        next_cyc();
        req = 1'b1; size = 3'd2; addr = 32'h20; rdy = 1'b0;
        next_cyc();
        #2;
        check_eq("trap_wait_stall", 32'(u_if.core_stall_o), 32'd1);
        next_cyc();
        req = 1'b0;
        #2;
        check_eq("trap_memreq", 32'(u_if.mem_req_o), 32'd0);
        check_eq("trap_stall", 32'(u_if.core_stall_o), 32'd0);
        check_eq("trap_err", 32'(u_if.bus_err_o), 32'd0);
        do_access(1'b0, 3'd5, 32'h22, 32'h0, 32'h9ABC_0000, 2, 4'b1100, 32'h0, 32'h00009ABC);

        // Asynchronous reset in the middle of a wait
        next_cyc();
        req = 1'b1; size = 3'd2; addr = 32'h30; rdy = 1'b0;
        next_cyc();
        #2;
        check_eq("arst_pre_stall", 32'(u_if.core_stall_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_memreq", 32'(u_if.mem_req_o), 32'd0);
        check_eq("arst_stall", 32'(u_if.core_stall_o), 32'd0);
        check_eq("arst_err", 32'(u_if.bus_err_o), 32'd0);
        next_cyc();
        #2;
        req = 1'b0;
        rst_n = 1'b1;
        do_access(1'b1, 3'd1, 32'h36, 32'h0000BEEF, 32'h0, 1, 4'b1100, 32'hBEEFBEEF, 32'h0);

`ifdef LSU_MISALIGN_EN
        next_cyc();
        req = 1'b1; we = 1'b0; size = 3'd2; addr = 32'h6; rdy = 1'b0;
        #2;
        check_eq("mis_flag", 32'(u_if.misalign_o), 32'd1);
        check_eq("mis_memreq", 32'(u_if.mem_req_o), 32'd0);
        check_eq("mis_stall", 32'(u_if.core_stall_o), 32'd0);
        next_cyc();
        rdy = 1'b1;
        #2;
        check_eq("mis_stay_idle", 32'(u_if.mem_req_o), 32'd0);
        next_cyc();
        req = 1'b0; rdy = 1'b0;
`endif

        // Randomized accesses against the reference model
        for (int t = 0; t < 60; t++) begin
            sz = 3'($urandom_range(0, 7));
            a  = $urandom;
            d  = $urandom;
            r  = $urandom;
            wv = 1'($urandom_range(0, 1));
`ifdef LSU_MISALIGN_EN
            if (nbytes(sz) == 2) a[0] = 1'b0;
            if (nbytes(sz) == 4) a[1:0] = 2'b00;
`endif
            do_access(wv, sz, a, d, r, $urandom_range(0, 3), m_be(sz, a), m_wd(sz, d), m_rd(sz, a, r));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
